icb_msp_master: RTL and testbench
=================================

// Module: icb_msp_master
// PURPOSE
//  ICB initiator driving the MSP mel-spectrogram slave from the core side.
//  Packs a 16-bit audio sample stream into 32-bit ICB write words for one hop, then issues ICB reads to fetch the packed 8-bit mel results.
//  Screens each read response for the slave's in-band error codes.
//  Sits between the audio front-end (sample stream) and the MSP slave port.
// PARAMETERS
//  BASE_ADDR   32'h1004_2000  write address (sample FIFO); reads use BASE_ADDR+4
//  N_WR_WORDS  80             write words per frame (160 samples = one hop)
//  N_RD_WORDS  10             read words per frame (40 mel bands x 8 bit)
//  ERR_CHECK   1              1: screen rdata for in-band error codes
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, synchronous, active-low
//  start          in   1   pulse: begin one frame (write phase, then read phase)
//  clr_err        in   1   pulse: leave ERR state
//  smp_valid      in   1   sample stream valid
//  smp_ready      out  1   sample stream ready
//  smp_data       in   16  audio sample
//  icb_cmd_valid  out  1   ICB command valid
//  icb_cmd_ready  in   1   ICB command ready
//  icb_cmd_addr   out  32  command address
//  icb_cmd_read   out  1   1=read, 0=write
//  icb_cmd_wdata  out  32  write data {second sample, first sample}
//  icb_cmd_wmask  out  4   byte mask; 4'hF on writes, 4'h0 on reads
//  icb_rsp_valid  in   1   ICB response valid
//  icb_rsp_ready  out  1   ICB response ready
//  icb_rsp_rdata  in   32  response data
//  icb_rsp_err    in   1   response error
//  mel_valid      out  1   mel word valid
//  mel_ready      in   1   mel word consumed
//  mel_data       out  32  four mel bytes, band 4k at [7:0]
//  busy           out  1   state != IDLE
//  done           out  1   one-cycle pulse at frame completion
//  err            out  1   high while in ERR
//  err_code       out  32  rdata (or 32'hFFFF_FFFF for rsp_err) latched on error
// BEHAVIOUR
//  Reset: state=IDLE.
//   All outputs 0; counters cleared; mel register empty.
//   A reset mid-transfer drops icb_cmd_valid at that edge; no cleanup transaction is issued.
//  Only one command is outstanding at a time. The next command is issued only after the response handshake.
//  FSM states and transitions:
//   IDLE: start=1 -> PACK with wr_cnt=rd_cnt=0. start is ignored in every other state.
//   PACK: smp_ready=1.
//    First sample accepted -> wdata[15:0].
//    Second sample accepted -> wdata[31:16], then -> WR_CMD.
//   WR_CMD: cmd_valid=1, read=0, addr=BASE_ADDR, wmask=4'hF.
//    addr/wdata/read are held stable until cmd_ready. On handshake -> WR_RSP.
//   WR_RSP: rsp_ready=1. On rsp_valid:
//    rsp_err -> ERR.
//    Else if wr_cnt==N_WR_WORDS-1 -> RD_CMD.
//    Else wr_cnt++ and -> PACK.
//   RD_CMD: cmd_valid=1, read=1, addr=BASE_ADDR+4, wmask=0. On handshake -> RD_RSP.
//   RD_RSP: rsp_ready = !mel_valid || mel_ready (one-entry output register). On response handshake:
//    Error -> ERR (no mel_valid). Error means rsp_err=1, or ERR_CHECK=1 and rdata[31:16] is 16'hF1F0 or 16'hB00F, or rdata==32'h57F7BE57.
//    Otherwise mel_data<=rdata and mel_valid<=1.
//    Then rd_cnt==N_RD_WORDS-1 -> DONE, else rd_cnt++ and -> RD_CMD.
//   DONE: done=1 for one cycle -> IDLE.
//   ERR: err=1; err_code is held. clr_err -> IDLE, which clears err and err_code.
//  mel_valid is independent of FSM state. It clears on mel_ready unless it is reloaded in the same cycle.
//  Best-case write throughput is 4 cycles/word; best-case read is 2 cycles/word.
//  Back-to-back start: a start in the same cycle as the DONE pulse is ignored.
// TESTING
//  Ready/valid always 1, 160 samples 0x0001..0x00A0, start.
//   -> 80 writes, first wdata=32'h0002_0001.
//   -> Then 10 reads at BASE_ADDR+4, done after the last read response; busy low one cycle later.
//  cmd_ready held 0 for 5 cycles during WR_CMD -> addr/wdata/read stable; no sample accepted.
//  Read rdata=32'hF1F0_F001 on the 3rd read -> err=1, err_code=32'hF1F0F001, mel_valid not set.
//   -> clr_err returns to IDLE.
//  icb_rsp_err=1 on write 7 -> ERR, err_code=32'hFFFF_FFFF, no further commands.
//  mel_ready=0 during reads -> after one word mel_valid stays 1 and rsp_ready=0.
//   -> Releasing mel_ready resumes the reads; all 10 words delivered in order.
//  rst_n=0 during WR_CMD -> next cycle icb_cmd_valid=0, busy=0.
//   -> A new start restarts from wr_cnt=0.

Source files
------------

// File: rtl/icb_msp_master.sv
// icb_msp_master: ICB initiator that packs 16-bit samples into MSP writes, then reads back packed mel words
// and screens each read response for the slave's in-band error codes.
module icb_msp_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h1004_2000,
  parameter int          N_WR_WORDS = 80,
  parameter int          N_RD_WORDS = 10,
  parameter bit          ERR_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr_err,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic [15:0] smp_data,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err,
  output logic        mel_valid,
  input  logic        mel_ready,
  output logic [31:0] mel_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] err_code
);
  typedef enum logic [2:0] {IDLE, PACK, WR_CMD, WR_RSP, RD_CMD, RD_RSP, DONE, ERR} state_t;
  localparam int WW = $clog2(N_WR_WORDS);
  localparam int RW = $clog2(N_RD_WORDS);
  state_t        r_state;
  logic [WW-1:0] r_wr_cnt;
  logic [RW-1:0] r_rd_cnt;
  logic          r_half;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mel_data;
  logic          r_mel_valid;
  logic [31:0]   r_err_code;
  logic          w_rd_hs;
  logic          w_rd_err;
  logic          w_mel_load;
  assign w_rd_hs    = r_state == RD_RSP && icb_rsp_valid && icb_rsp_ready;
  assign w_rd_err   = icb_rsp_err || (ERR_CHECK && (icb_rsp_rdata[31:16] == 16'hF1F0 ||
                      icb_rsp_rdata[31:16] == 16'hB00F || icb_rsp_rdata == 32'h57F7_BE57));
  assign w_mel_load = w_rd_hs && !w_rd_err;
  assign smp_ready     = r_state == PACK;
  assign icb_cmd_valid = r_state == WR_CMD || r_state == RD_CMD;
  assign icb_cmd_read  = r_state == RD_CMD;
  assign icb_cmd_addr  = r_state == RD_CMD ? BASE_ADDR + 32'd4 : r_state == WR_CMD ? BASE_ADDR : 32'h0;
  assign icb_cmd_wdata = r_state == WR_CMD ? r_wdata : 32'h0;
  assign icb_cmd_wmask = r_state == WR_CMD ? 4'hF : 4'h0;
  // One-entry mel register: a read response is only taken once it has somewhere to go
  assign icb_rsp_ready = r_state == WR_RSP || (r_state == RD_RSP && (!r_mel_valid || mel_ready));
  assign mel_valid     = r_mel_valid;
  assign mel_data      = r_mel_data;
  assign busy          = r_state != IDLE;
  assign done          = r_state == DONE;
  assign err           = r_state == ERR;
  assign err_code      = r_err_code;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_half      <= 1'b0;
      r_wdata     <= '0;
      r_mel_data  <= '0;
      r_mel_valid <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_mel_valid <= w_mel_load || (r_mel_valid && !mel_ready);
      if (w_mel_load) r_mel_data <= icb_rsp_rdata;
      case (r_state)
        IDLE: if (start) begin
          r_state  <= PACK;
          r_wr_cnt <= '0;
          r_rd_cnt <= '0;
          r_half   <= 1'b0;
        end
        PACK: if (smp_valid) begin
          r_half <= !r_half;
          if (r_half) begin
            r_wdata[31:16] <= smp_data;
            r_state        <= WR_CMD;
          end else r_wdata[15:0] <= smp_data;
        end
        WR_CMD: if (icb_cmd_ready) r_state <= WR_RSP;
        WR_RSP: if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            r_state    <= ERR;
            r_err_code <= '1;
          end else if (r_wr_cnt == WW'(N_WR_WORDS - 1)) r_state <= RD_CMD;
          else begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            r_state  <= PACK;
          end
        end
        RD_CMD: if (icb_cmd_ready) r_state <= RD_RSP;
        RD_RSP: if (w_rd_hs) begin
          if (w_rd_err) begin
            r_state    <= ERR;
            r_err_code <= icb_rsp_err ? '1 : icb_rsp_rdata;
          end else if (r_rd_cnt == RW'(N_RD_WORDS - 1)) r_state <= DONE;
          else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            r_state  <= RD_CMD;
          end
        end
        DONE: r_state <= IDLE;
        ERR: if (clr_err) begin
          r_state    <= IDLE;
          r_err_code <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_icb_msp_master.sv
// tb_icb_msp_master: directed bench with a sample source, a one-outstanding ICB slave model
// and scoreboards for write data and mel words.
module tb_icb_msp_master;
  localparam logic [31:0] BASE = 32'h1004_2000;
  logic clk = 0, rst_n = 0, start = 0, clr_err = 0;
  logic smp_valid = 0, smp_ready;
  logic [15:0] smp_data = 0;
  logic icb_cmd_valid, icb_cmd_ready = 1, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0] icb_cmd_wmask;
  logic icb_rsp_valid = 0, icb_rsp_ready, icb_rsp_err = 0;
  logic [31:0] icb_rsp_rdata = 0;
  logic mel_valid, mel_ready = 1;
  logic [31:0] mel_data;
  logic busy, done, err;
  logic [31:0] err_code;
  int n_vec = 0, n_err = 0;
  int n_wr = 0, n_rd = 0, n_rrsp = 0, n_mel = 0, smp_idx = 0;
  int err_wr_idx = -1, err_rd_idx = -1;
  logic [31:0] err_rd_val = 0, first_wd = 0;
  logic [15:0] smp_lo = 0;
  logic smp_half = 0, pend_rd = 0;
  logic [31:0] exp_wq[$], exp_mq[$];

  icb_msp_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_err(clr_err),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_data(mel_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input int i);
    return 32'h1020_3040 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are sampled at the falling edge, new stimulus is driven 1ns after the rising edge.
  task automatic cycle();
    logic hs_s, hs_c, hs_r, hs_m, rd;
    logic [31:0] e;
    @(negedge clk);
    hs_s = smp_valid && smp_ready;
    hs_c = icb_cmd_valid && icb_cmd_ready;
    hs_r = icb_rsp_valid && icb_rsp_ready;
    hs_m = mel_valid && mel_ready;
    rd   = icb_cmd_read;
    if (hs_c && rd) begin
      check("rd_addr", icb_cmd_addr, BASE + 32'd4);
      check("rd_mask", 32'(icb_cmd_wmask), 32'h0);
      n_rd++;
    end
    if (hs_c && !rd) begin
      if (exp_wq.size() > 0) e = exp_wq.pop_front(); else e = 'x;
      if (n_wr == 0) first_wd = icb_cmd_wdata;
      check("wr_addr", icb_cmd_addr, BASE);
      check("wr_mask", 32'(icb_cmd_wmask), 32'hF);
      check("wr_data", icb_cmd_wdata, e);
      n_wr++;
    end
    if (hs_r && pend_rd) n_rrsp++;
    if (hs_m) begin
      if (exp_mq.size() > 0) e = exp_mq.pop_front(); else e = 'x;
      check("mel_data", mel_data, e);
      n_mel++;
    end
    if (hs_s) begin
      if (smp_half) exp_wq.push_back({smp_data, smp_lo}); else smp_lo = smp_data;
      smp_half = !smp_half;
      smp_idx++;
    end
    @(posedge clk);
    #1;
    smp_valid = smp_idx < 160;
    smp_data  = 16'(smp_idx + 1);
    if (hs_r) begin
      icb_rsp_valid = 0;
      icb_rsp_err   = 0;
      icb_rsp_rdata = 0;
    end
    if (hs_c) begin
      icb_rsp_valid = 1;
      pend_rd       = rd;
      icb_rsp_err   = !rd && (n_wr - 1 == err_wr_idx);
      icb_rsp_rdata = !rd ? 32'h0 : (n_rd - 1 == err_rd_idx) ? err_rd_val : rd_word(n_rd - 1);
      if (rd && n_rd - 1 != err_rd_idx) exp_mq.push_back(icb_rsp_rdata);
    end
  endtask

  task automatic new_frame();
    exp_wq.delete();
    exp_mq.delete();
    n_wr = 0; n_rd = 0; n_rrsp = 0; n_mel = 0;
    smp_idx = 0; smp_half = 0; first_wd = 'x;
    smp_valid = 1; smp_data = 16'd1;
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < 3000 && n_rrsp < 10; i++) cycle();
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'h1);
    check({tag, "_nwr"}, n_wr, 80);
    check({tag, "_nrd"}, n_rd, 10);
    check({tag, "_first_wd"}, first_wd, 32'h0002_0001);
    cycle();
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_busy_after"}, 32'(busy), 32'h0);
    cycle();
    check({tag, "_nmel"}, n_mel, 10);
    check({tag, "_mq_left"}, exp_mq.size(), 0);
  endtask

  task automatic rd_err_case(input string tag, input int idx, input logic [31:0] val);
    err_rd_idx = idx;
    err_rd_val = val;
    new_frame();
    for (int i = 0; i < 3000 && !err; i++) cycle();
    check({tag, "_err"}, 32'(err), 32'h1);
    check({tag, "_code"}, err_code, val);
    check({tag, "_mel_valid"}, 32'(mel_valid), 32'h0);
    check({tag, "_nmel"}, n_mel, idx);
    check({tag, "_nrd"}, n_rd, idx + 1);
    repeat (3) cycle();
    check({tag, "_held"}, {err_code[30:0], err}, {val[30:0], 1'b1});
    check({tag, "_no_cmd"}, 32'(icb_cmd_valid), 32'h0);
    clr_err = 1;
    cycle();
    clr_err = 0;
    check({tag, "_clr"}, {30'h0, err, busy}, 32'h0);
    check({tag, "_clr_code"}, err_code, 32'h0);
    err_rd_idx = -1;
  endtask

  initial begin
    rst_n = 0;
    repeat (3) cycle();
    check("rst_flags", {24'h0, smp_ready, icb_cmd_valid, icb_cmd_read, icb_rsp_ready, mel_valid, busy, done, err}, 32'h0);
    check("rst_err_code", err_code, 32'h0);
    check("rst_addr", icb_cmd_addr, 32'h0);
    check("rst_mel_data", mel_data, 32'h0);
    check("rst_wmask", 32'(icb_cmd_wmask), 32'h0);
    rst_n = 1;
    cycle();
    // Nominal frame, with a start raised during the DONE cycle
    new_frame();
    check("pack_busy", 32'(busy), 32'h1);
    check("pack_ready", 32'(smp_ready), 32'h1);
    for (int i = 0; i < 3000 && n_rrsp < 10; i++) cycle();
    check("nom_done", 32'(done), 32'h1);
    check("nom_nwr", n_wr, 80);
    check("nom_nrd", n_rd, 10);
    check("nom_first_wd", first_wd, 32'h0002_0001);
    start = 1;
    cycle();
    start = 0;
    check("nom_done_pulse", 32'(done), 32'h0);
    check("nom_busy_after", 32'(busy), 32'h0);
    cycle();
    check("start_in_done_ignored", 32'(busy), 32'h0);
    check("nom_nmel", n_mel, 10);
    // Command stall in WR_CMD, then reset mid-command
    icb_cmd_ready = 0;
    new_frame();
    for (int i = 0; i < 20 && !icb_cmd_valid; i++) cycle();
    repeat (5) begin
      cycle();
      check("stall_valid", 32'(icb_cmd_valid), 32'h1);
      check("stall_addr", icb_cmd_addr, BASE);
      check("stall_wdata", icb_cmd_wdata, 32'h0002_0001);
      check("stall_read", 32'(icb_cmd_read), 32'h0);
      check("stall_smp", smp_idx, 2);
    end
    rst_n = 0;
    cycle();
    check("rst_mid_valid", 32'(icb_cmd_valid), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    icb_cmd_ready = 1;
    icb_rsp_valid = 0;
    rst_n = 1;
    cycle();
    new_frame();
    finish_frame("restart");
    // In-band error codes on read responses
    rd_err_case("rderr_f1f0", 2, 32'hF1F0_F001);
    rd_err_case("rderr_b00f", 0, 32'hB00F_1234);
    rd_err_case("rderr_57f7", 5, 32'h57F7_BE57);
    // Bus error on write 7
    err_wr_idx = 6;
    new_frame();
    for (int i = 0; i < 3000 && !err; i++) cycle();
    check("wrerr_err", 32'(err), 32'h1);
    check("wrerr_code", err_code, 32'hFFFF_FFFF);
    check("wrerr_nwr", n_wr, 7);
    repeat (10) cycle();
    check("wrerr_nwr_after", n_wr, 7);
    check("wrerr_nrd_after", n_rd, 0);
    check("wrerr_no_cmd", 32'(icb_cmd_valid), 32'h0);
    check("wrerr_no_smp", smp_idx, 14);
    clr_err = 1;
    cycle();
    clr_err = 0;
    check("wrerr_clr", {30'h0, err, busy}, 32'h0);
    err_wr_idx = -1;
    // Mel sink back-pressure during reads
    mel_ready = 0;
    new_frame();
    for (int i = 0; i < 3000 && !mel_valid; i++) cycle();
    repeat (6) cycle();
    check("melstall_valid", 32'(mel_valid), 32'h1);
    check("melstall_data", mel_data, rd_word(0));
    check("melstall_rsp_ready", 32'(icb_rsp_ready), 32'h0);
    check("melstall_rsp_valid", 32'(icb_rsp_valid), 32'h1);
    check("melstall_nrd", n_rd, 2);
    mel_ready = 1;
    finish_frame("melstall");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
